// File: rtl/ahb_slave_if.sv
// ----------------------------------------------------------------------------
// ahb_slave_if
//
// AHB-side front end of the AHB-to-APB bridge. Qualifies AHB transfers,
// decodes the address into one of NUM_SEL contiguous peripheral regions,
// pipelines address / write data / direction for the APB controller, and
// drives HREADYOUT / HRESP back to the master. Unmapped addresses and SEQ
// transfers that do not follow an accepted beat get the two-cycle AHB ERROR
// response.
//
// Handshake: a transfer is taken from the master on a cycle where
// Hreadyin & Hreadyout & Htrans[1] are all high. Such a transfer is either
// forwarded (valid=1) or rejected (illegal, ERROR response). The pipeline
// registers advance on every cycle where Hreadyin & Hreadyout are high, whether
// or not that cycle carried a valid transfer; the APB controller only acts on
// valid. Hready_apb=0 holds Hreadyout low in the OK state, which stalls the
// master and freezes the pipeline.
//
// Ports:
//   Hclk        in   bus clock, rising edge
//   Hreset      in   synchronous active-high reset
//   Haddr       in   [31:0] AHB address
//   Hwdata      in   [31:0] AHB write data (data phase)
//   Hwrite      in   1 = write, 0 = read
//   Htrans      in   [1:0] IDLE/BUSY/NONSEQ/SEQ
//   Hreadyin    in   bus-level HREADY
//   Hready_apb  in   ready from APB controller, 0 = stall
//   Hreadyout   out  ready to master
//   Hresp       out  [1:0] 00 OKAY, 01 ERROR
//   valid       out  qualified transfer this cycle (combinational)
//   Haddr1/2    out  [31:0] address delayed by 1/2 enabled cycles
//   Hwdata1/2   out  [31:0] write data delayed by 1/2 enabled cycles
//   Hwritereg   out  Hwrite delayed by 1 enabled cycle
//   tempselx    out  [NUM_SEL-1:0] one-hot peripheral select (combinational)
//   beat_cnt    out  [3:0] accepted beats in current burst, saturating at 15
// ----------------------------------------------------------------------------
module ahb_slave_if #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          REGION_LOG2 = 26,
    parameter int          NUM_SEL     = 3
) (
    input  logic               Hclk,
    input  logic               Hreset,
    input  logic [31:0]        Haddr,
    input  logic [31:0]        Hwdata,
    input  logic               Hwrite,
    input  logic [1:0]         Htrans,
    input  logic               Hreadyin,
    input  logic               Hready_apb,
    output logic               Hreadyout,
    output logic [1:0]         Hresp,
    output logic               valid,
    output logic [31:0]        Haddr1,
    output logic [31:0]        Haddr2,
    output logic [31:0]        Hwdata1,
    output logic [31:0]        Hwdata2,
    output logic               Hwritereg,
    output logic [NUM_SEL-1:0] tempselx,
    output logic [3:0]         beat_cnt
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } resp_state_t;

    resp_state_t resp_state;

    logic [31:0] offset;
    logic [31:0] idx;
    logic        mapped;
    logic        active;
    logic        illegal;
    logic        en;

    // Address decode. The explicit Haddr >= BASE_ADDR test matters because
    // the subtraction wraps for addresses below the window.
    always_comb begin
        offset   = Haddr - BASE_ADDR;
        idx      = offset >> REGION_LOG2;
        mapped   = (Haddr >= BASE_ADDR) && (idx < 32'(NUM_SEL));
        tempselx = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            tempselx[i] = mapped && (idx == 32'(i));
        end
    end

    // Response outputs are a pure decode of the state register, except that
    // the OK state passes the APB controller's stall straight through.
    always_comb begin
        Hreadyout = Hready_apb;
        Hresp     = RESP_OKAY;
        case (resp_state)
            ST_ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = RESP_ERROR;
            end
            ST_ERR2: begin
                Hreadyout = 1'b1;
                Hresp     = RESP_ERROR;
            end
            default: begin
                Hreadyout = Hready_apb;
                Hresp     = RESP_OKAY;
            end
        endcase
    end

    // A SEQ with no beat counted yet has no burst to continue, so it is
    // treated as a protocol error alongside unmapped addresses.
    always_comb begin
        en      = Hreadyin & Hreadyout;
        active  = en & Htrans[1];
        illegal = active & (~mapped | ((Htrans == TRANS_SEQ) & (beat_cnt == 4'd0)));
        valid   = active & ~illegal;
    end

    // Address / data / direction pipeline.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            Haddr1    <= '0;
            Haddr2    <= '0;
            Hwdata1   <= '0;
            Hwdata2   <= '0;
            Hwritereg <= 1'b0;
        end else if (en) begin
            Haddr1    <= Haddr;
            Haddr2    <= Haddr1;
            Hwdata1   <= Hwdata;
            Hwdata2   <= Hwdata1;
            Hwritereg <= Hwrite;
        end
    end

    // Burst beat counter. BUSY and IDLE never reach the valid branch, so
    // BUSY holds and only an enabled IDLE clears.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            beat_cnt <= 4'd0;
        end else if (illegal) begin
            beat_cnt <= 4'd0;
        end else if (valid) begin
            if (Htrans == TRANS_NONSEQ) begin
                beat_cnt <= 4'd1;
            end else if (beat_cnt != 4'hF) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
        end else if (en && (Htrans == TRANS_IDLE)) begin
            beat_cnt <= 4'd0;
        end
    end

    // Two-cycle ERROR response. ERR2 drives Hreadyout high, so the master may
    // present a new transfer there; if that one is illegal too, the
    // response restarts.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            resp_state <= ST_OK;
        end else begin
            case (resp_state)
                ST_OK:   resp_state <= illegal ? ST_ERR1 : ST_OK;
                ST_ERR1: resp_state <= ST_ERR2;
                ST_ERR2: resp_state <= illegal ? ST_ERR1 : ST_OK;
                default: resp_state <= ST_OK;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_if.sv
module tb_ahb_slave_if;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    // ---------------- clock / reset / DUT ----------------
    logic        Hclk;
    logic        Hreset;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hwrite;
    logic [1:0]  Htrans;
    logic        Hreadyin;
    logic        Hready_apb;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic        valid;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic [31:0] Hwdata2;
    logic        Hwritereg;
    logic [2:0]  tempselx;
    logic [3:0]  beat_cnt;

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    ahb_slave_if dut (
        .Hclk       (Hclk),
        .Hreset     (Hreset),
        .Haddr      (Haddr),
        .Hwdata     (Hwdata),
        .Hwrite     (Hwrite),
        .Htrans     (Htrans),
        .Hreadyin   (Hreadyin),
        .Hready_apb (Hready_apb),
        .Hreadyout  (Hreadyout),
        .Hresp      (Hresp),
        .valid      (valid),
        .Haddr1     (Haddr1),
        .Haddr2     (Haddr2),
        .Hwdata1    (Hwdata1),
        .Hwdata2    (Hwdata2),
        .Hwritereg  (Hwritereg),
        .tempselx   (tempselx),
        .beat_cnt   (beat_cnt)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_a1, m_a2, m_d1, m_d2;
    logic        m_w;
    int          m_beat;
    int          m_st;      // 0 OK, 1 first ERROR cycle, 2 second ERROR cycle
    bit          known = 0;

    // scoreboard of forwarded transfers: {Hwrite, Haddr}
    logic [32:0] exp_q[$];

    function automatic void decode(input logic [31:0] a, output bit m, output logic [2:0] s);
        longint unsigned ua   = 64'(a);
        longint unsigned base = 64'h8000_0000;
        longint unsigned rsz  = 64'h0400_0000;
        m = 0;
        s = 3'b000;
        for (int k = 0; k < 3; k++) begin
            if (ua >= base + 64'(k) * rsz && ua < base + 64'(k + 1) * rsz) begin
                m    = 1;
                s[k] = 1'b1;
            end
        end
    endfunction

    // One bus cycle: drive inputs just after a rising edge, check combinational
    // outputs, advance model across the edge, then check registered outputs.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [1:0] t, input logic rin, input logic rapb,
                       input logic rst);
        bit          mp, act, ill, vld, en, dut_vld;
        logic [2:0]  sel;
        logic        rdy;
        logic [1:0]  rsp;
        logic [32:0] e;
        Haddr = a; Hwdata = d; Hwrite = w; Htrans = t;
        Hreadyin = rin; Hready_apb = rapb; Hreset = rst;
        #1;
        decode(a, mp, sel);
        rdy = (m_st == 0) ? rapb : (m_st == 2);
        rsp = (m_st == 0) ? 2'b00 : 2'b01;
        act = rin && rdy && t[1];
        ill = act && (!mp || (t == T_SEQ && m_beat == 0));
        vld = act && !ill;
        dut_vld = (valid === 1'b1);
        if (known) begin
            check("hreadyout", 64'(Hreadyout), 64'(rdy));
            check("hresp", 64'(Hresp), 64'(rsp));
            check("valid", 64'(valid), 64'(vld));
            check("tempselx", 64'(tempselx), 64'(sel));
            if (vld) exp_q.push_back({w, a});
        end
        @(posedge Hclk);
        #1;
        en = rin && rdy;
        if (rst) begin
            m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0; m_w = 0; m_beat = 0; m_st = 0;
            exp_q.delete();
            known = 1;
        end else begin
            if (en) begin
                m_a2 = m_a1; m_a1 = a; m_d2 = m_d1; m_d1 = d; m_w = w;
            end
            if (ill) m_beat = 0;
            else if (vld) m_beat = (t == T_NONSEQ) ? 1 : ((m_beat == 15) ? 15 : m_beat + 1);
            else if (en && t == T_IDLE) m_beat = 0;
            case (m_st)
                0:       m_st = ill ? 1 : 0;
                1:       m_st = 2;
                default: m_st = ill ? 1 : 0;
            endcase
            if (dut_vld) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_xfer", 64'({Hwritereg, Haddr1}), 64'(e));
                end
            end
        end
        if (known) begin
            check("haddr1", 64'(Haddr1), 64'(m_a1));
            check("haddr2", 64'(Haddr2), 64'(m_a2));
            check("hwdata1", 64'(Hwdata1), 64'(m_d1));
            check("hwdata2", 64'(Hwdata2), 64'(m_d2));
            check("hwritereg", 64'(Hwritereg), 64'(m_w));
            check("beat_cnt", 64'(beat_cnt), 64'(m_beat));
        end
    endtask

    // normal-traffic cycle
    task automatic go(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [1:0] t);
        cyc(a, d, w, t, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle();
        cyc(32'h0, 32'h0, 1'b0, T_IDLE, 1'b1, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 5);
        case (r)
            0, 1, 2: rand_addr = 32'h8000_0000 + 32'(r) * 32'h0400_0000 + ($urandom & 32'h03FF_FFFF);
            3:       rand_addr = 32'hFFFF_FFFF;
            4:       rand_addr = $urandom & 32'h7FFF_FFFF;
            default: rand_addr = 32'h8C00_0000 + ($urandom & 32'h00FF_FFFF);
        endcase
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] wd;
        Haddr = 0; Hwdata = 0; Hwrite = 0; Htrans = T_IDLE;
        Hreadyin = 1; Hready_apb = 1; Hreset = 1;
        m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0; m_w = 0; m_beat = 0; m_st = 0;
        @(posedge Hclk);
        #1;

        // reset with random inputs
        for (int i = 0; i < 2; i++)
            cyc($urandom, $urandom, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'b1);

        // single write to peripheral 0, data in the following cycle
        go(32'h8000_0001, 32'h0, 1'b1, T_NONSEQ);
        check("ws_beat", 64'(beat_cnt), 64'(1));
        check("ws_addr1", 64'(Haddr1), 64'h8000_0001);
        go(32'h0, 32'h80, 1'b0, T_IDLE);
        check("ws_wdata1", 64'(Hwdata1), 64'h80);
        idle();

        // INCR4 read to peripheral 1
        go(32'h8400_0001, $urandom, 1'b0, T_NONSEQ);
        for (int i = 2; i <= 4; i++) begin
            go(32'h8400_0000 + 32'(i), $urandom, 1'b0, T_SEQ);
            check("incr4_beat", 64'(beat_cnt), 64'(i));
        end
        check("incr4_addr2", 64'(Haddr2), 64'h8400_0003);
        idle();
        check("incr4_clr", 64'(beat_cnt), 64'(0));

        // stall for 3 cycles mid-burst; master holds the SEQ beat
        go(32'h8000_0100, 32'h0, 1'b1, T_NONSEQ);
        go(32'h8000_0104, 32'h1111, 1'b1, T_SEQ);
        wd = 32'h2222;
        for (int i = 0; i < 3; i++)
            cyc(32'h8000_0108, wd, 1'b1, T_SEQ, 1'b1, 1'b0, 1'b0);
        check("stall_beat", 64'(beat_cnt), 64'(2));
        go(32'h8000_0108, wd, 1'b1, T_SEQ);
        go(32'h8000_010C, 32'h3333, 1'b1, T_SEQ);
        check("stall_resume", 64'(beat_cnt), 64'(4));
        go(32'h0, 32'h4444, 1'b0, T_IDLE);

        // unmapped access: two-cycle ERROR
        go(32'h8C00_0000, 32'h0, 1'b0, T_NONSEQ);
        check("unm_err1_rdy", 64'(Hreadyout), 64'(0));
        check("unm_err1_rsp", 64'(Hresp), 64'(1));
        idle();
        idle();
        check("unm_ok_rsp", 64'(Hresp), 64'(0));

        // SEQ directly after IDLE is illegal
        go(32'h8000_0010, 32'h0, 1'b0, T_SEQ);
        check("iseq_beat", 64'(beat_cnt), 64'(0));
        idle();
        idle();
        // same again, reset during the first ERROR cycle
        go(32'h8000_0010, 32'h0, 1'b0, T_SEQ);
        cyc(32'h0, 32'h0, 1'b0, T_IDLE, 1'b1, 1'b1, 1'b1);
        check("rst_err_rsp", 64'(Hresp), 64'(0));
        idle();

        // illegal again in the second ERROR cycle restarts the response
        go(32'h0000_1000, 32'h0, 1'b0, T_NONSEQ);
        idle();
        go(32'hFFFF_FFFF, 32'h0, 1'b0, T_NONSEQ);
        check("err2_re_rdy", 64'(Hreadyout), 64'(0));
        idle();
        idle();

        // region boundaries
        go(32'h7FFF_FFFF, 32'h0, 1'b0, T_NONSEQ); idle(); idle();
        go(32'h8BFF_FFFF, 32'h0, 1'b1, T_NONSEQ); idle();
        go(32'h8800_0000, 32'h0, 1'b0, T_NONSEQ);

        // BUSY holds the count; long burst saturates at 15
        go(32'h8800_0004, 32'h0, 1'b0, T_BUSY);
        check("busy_hold", 64'(beat_cnt), 64'(1));
        for (int i = 0; i < 17; i++) go(32'h8800_0004 + 32'(4 * i), $urandom, 1'b0, T_SEQ);
        check("sat_beat", 64'(beat_cnt), 64'(15));
        idle();

        // random traffic
        for (int i = 0; i < 400; i++)
            cyc(rand_addr(), $urandom, 1'($urandom),
                2'($urandom_range(0, 3)),
                1'($urandom_range(0, 7) != 0),
                1'($urandom_range(0, 5) != 0),
                1'($urandom_range(0, 59) == 0));
        idle();
        idle();

        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
AHB-side front end of the AHB-to-APB bridge. It sits directly downstream of the AHB master and upstream of the APB controller FSM. It qualifies AHB transfers, decodes the address to one of three APB peripheral selects, and pipelines address, data and direction for the APB controller. It also generates HREADYOUT and HRESP back to the master, including the two-cycle AHB ERROR response for unmapped addresses and illegal SEQ transfers.

Parameters:
BASE_ADDR, 32'h8000_0000, start of the bridge address window
REGION_LOG2, 26, log2 of per-peripheral region size (64 MB)
NUM_SEL, 3, number of APB peripheral regions, contiguous from BASE_ADDR

Ports:
Hclk  in  1  bus clock; all logic on rising edge
Hreset  in  1  synchronous, active-high reset
Haddr  in  32  AHB address from master
Hwdata  in  32  AHB write data (data phase)
Hwrite  in  1  1=write, 0=read
Htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
Hreadyin  in  1  bus-level HREADY from master side
Hready_apb  in  1  ready from APB controller; 0 = stall
Hreadyout  out  1  ready to master
Hresp  out  2  00 OKAY, 01 ERROR
valid  out  1  qualified transfer this cycle (combinational)
Haddr1  out  32  address, 1 cycle delayed
Haddr2  out  32  address, 2 cycles delayed
Hwdata1  out  32  write data, 1 cycle delayed
Hwdata2  out  32  write data, 2 cycles delayed
Hwritereg  out  1  Hwrite, 1 cycle delayed
tempselx  out  NUM_SEL  one-hot peripheral select (combinational from Haddr)
beat_cnt  out  4  accepted beats in current burst, saturates at 15

Behaviour:
- Reset (Hreset=1 at posedge): Haddr1/2, Hwdata1/2 = 0; Hwritereg = 0; beat_cnt = 0; resp state = OK. Hreadyout then evaluates to Hready_apb and Hresp = 00. Reset mid-transfer or mid-error aborts immediately; there is no residue.
- Decode: idx = (Haddr - BASE_ADDR) >> REGION_LOG2. If Haddr >= BASE_ADDR and idx < NUM_SEL, tempselx = 1<<idx and mapped = 1. Otherwise tempselx = 0 and mapped = 0.
- active = Hreadyin & Hreadyout & Htrans[1]. BUSY and IDLE are never active.
- illegal = active & (~mapped | (Htrans==SEQ & beat_cnt==0)).
- valid = active & ~illegal. Combinational, with no latency.
- Pipeline enable: en = Hreadyin & Hreadyout.
  - On en: Haddr1<=Haddr, Haddr2<=Haddr1, Hwdata1<=Hwdata, Hwdata2<=Hwdata1, Hwritereg<=Hwrite.
  - When en=0, all pipeline registers hold.
- beat_cnt, updated on valid:
  - NONSEQ loads 1.
  - SEQ increments, saturating at 15.
  - When en=1 and Htrans=IDLE, it clears to 0.
  - BUSY holds.
  - An illegal transfer clears it to 0.
- Response FSM (states OK, ERR1, ERR2):
  - OK: Hreadyout = Hready_apb, Hresp = 00. On illegal, go to ERR1.
  - ERR1: Hreadyout = 0, Hresp = 01. Unconditionally go to ERR2.
  - ERR2: Hreadyout = 1, Hresp = 01. Go to OK; if illegal is asserted again in this cycle, go to ERR1.
  - While in ERR1/ERR2, Hready_apb is ignored for Hreadyout.
- An illegal transfer never asserts valid and never reaches the APB side. The pipeline still advances on en, since the APB FSM gates on valid.
- Simultaneous Hready_apb=0 and a new NONSEQ: the transfer is not active and not counted; the master holds it and it is accepted on the first cycle Hready_apb=1.
- Address wrap: Haddr below BASE_ADDR, or at/after BASE_ADDR + NUM_SEL<<REGION_LOG2 (including 0xFFFF_FFFF), is unmapped.

Test Plan:
- Reset: assert Hreset for 2 cycles with random inputs -> all pipeline outputs 0, beat_cnt 0, Hresp 00, Hreadyout = Hready_apb.
- Single write: NONSEQ, Haddr=8000_0001, Hwrite=1, then data 0x80 -> valid=1 in cycle 0; tempselx=001; next cycle Haddr1=8000_0001, Hwritereg=1; following cycle Hwdata1=0x80; beat_cnt=1.
- INCR4 read: NONSEQ 8400_0001 then SEQ 8400_0002..0004 -> tempselx=010; valid on 4 cycles; beat_cnt 1,2,3,4; IDLE afterwards -> beat_cnt 0; Haddr2 trails Haddr by 2 cycles.
- Stall: Hready_apb=0 for 3 cycles mid-burst -> Hreadyout=0; Haddr1/2, Hwdata1/2 and beat_cnt frozen; resumes with no lost or duplicated beat.
- Unmapped: NONSEQ at 8C00_0000 -> valid=0, tempselx=000; next cycle Hreadyout=0/Hresp=01; then Hreadyout=1/Hresp=01; then OKAY.
- Illegal SEQ: SEQ at 8000_0010 directly after IDLE -> same two-cycle ERROR, valid never asserted, beat_cnt stays 0. Repeat with Hreset asserted during ERR1 -> next cycle Hresp=00.
